mem_responder: RTL

Single-port on-chip memory target for the core's unified memory bus. It is the responder end of the `memory_*` valid/ready interface driven by the core's arbiter. It accepts one request at a time, optionally inserts separate wait states for instruction and data accesses, performs byte-strobed writes or word reads on an internal word array, and returns one `memory_ready` pulse per request. Out-of-range addresses are flagged on `memory_error`.

---
 rtl/mem_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port word memory target for the memory_* valid/ready bus
// Optional wait-state insertion is compiled in with `define MEM_RESPONDER_WAIT_EN.
module mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          DEPTH      = 4096,
    parameter int          DATA_WAIT  = 1,
    parameter int          INSTR_WAIT = 0
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        memory_error
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_responder: DEPTH must be a power of two >= 2");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("mem_responder: BASE_ADDR must be word aligned");
    end
    if (DATA_WAIT < 0 || DATA_WAIT > 15 || INSTR_WAIT < 0 || INSTR_WAIT > 15) begin : g_bad_wait
        $error("mem_responder: wait parameters must be 0..15");
    end

`ifdef MEM_RESPONDER_WAIT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    localparam logic [3:0] DW = 4'(DATA_WAIT);
    localparam logic [3:0] IW = 4'(INSTR_WAIT);

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic [3:0]  w_sel;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_t;

    logic unused_instr;
    assign unused_instr = memory_instr;
`endif

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH];

    logic          do_access;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wstrb;
    logic [32:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          mem_we;

    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        rdata_d   = 32'h0;
        do_access = 1'b0;
        acc_addr  = memory_addr;
        acc_wdata = memory_wdata;
        acc_wstrb = memory_wstrb;
`ifdef MEM_RESPONDER_WAIT_EN
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        instr_d   = instr_q;
        w_sel     = memory_instr ? IW : DW;
`endif
        case (state_q)
            S_IDLE: begin
                if (memory_valid) begin
`ifdef MEM_RESPONDER_WAIT_EN
                    addr_d  = memory_addr;
                    wdata_d = memory_wdata;
                    wstrb_d = memory_wstrb;
                    instr_d = memory_instr;
                    cnt_d   = w_sel;
                    if (w_sel == 4'd0) begin
                        do_access = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        state_d   = S_WAIT;
                    end
`else
                    do_access = 1'b1;
                    state_d   = S_RESP;
`endif
                end
            end
`ifdef MEM_RESPONDER_WAIT_EN
            // Bus inputs are ignored here; the access uses the latched request.
            S_WAIT: begin
                acc_addr  = addr_q;
                acc_wdata = wdata_q;
                acc_wstrb = wstrb_q;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    do_access = 1'b1;
                    state_d   = S_RESP;
                end
            end
`endif
            // The initiator still holds memory_valid here, so it must not be re-accepted.
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // 33-bit offset keeps the upper bound check from wrapping near 2^32.
        off      = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
        in_range = (acc_addr >= BASE_ADDR) && (off < SPAN);
        idx      = off[AW+1:2];

        if (do_access) begin
            ready_d = 1'b1;
            if (!in_range) begin
                error_d = 1'b1;
            end else if (acc_wstrb == 4'b0000) begin
                rdata_d = mem[idx];
            end
        end
        mem_we = do_access && in_range && (acc_wstrb != 4'b0000) && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= 32'h0;
`ifdef MEM_RESPONDER_WAIT_EN
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            instr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
`ifdef MEM_RESPONDER_WAIT_EN
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
`endif
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) begin
                    mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign memory_rdata = rdata_q;
    assign memory_ready = ready_q;
    assign memory_error = error_q;

endmodule
